// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and defaults for the IFU/LSU memory port arbiter.
//   ImmWidth is the architectural register width; address and data buses
//   are sized from it.
package mem_port_arbiter_pkg;

  localparam int ImmWidth       = 64;
  localparam int DefStarveLimit = 4;
  localparam int DefTimeoutCyc  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arbState_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IFU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   One request/response memory port. Used for the IFU side, the LSU side
//   and the shared memory side of the arbiter.
//   master: drives req_valid, addr, wen, wdata, wmask, rsp_ready
//   slave : drives req_ready, rsp_valid, rsp_data
//   The IFU never writes; its wen/wdata/wmask are tied off by the IFU.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ImmWidth,
  parameter int DATA_W = ImmWidth
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;

  modport master (
    output req_valid, addr, wen, wdata, wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// bus_watchdog
//   Saturating cycle counter with clear and enable, plus a sticky overflow
//   flag. The flag sets on the enabled cycle in which the count already sits
//   at TIMEOUT_CYC-1, i.e. after TIMEOUT_CYC enabled cycles since the last
//   clear. Only rst clears the flag.
//   Ports: clk, rst (async, active-high), clr, en, overflow.
module bus_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic overflow
);

  localparam int              CntW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] wdCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdCnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (clr) begin
        wdCnt <= '0;
      end else if (en && (wdCnt != LastCnt)) begin
        wdCnt <= wdCnt + CntW'(1);
      end
      if (en && !clr && (wdCnt == LastCnt)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between IFU and LSU. One transaction at a
//   time: accept in IDLE, present registered request in REQ, pass response
//   through in RSP. LSU has fixed priority; after STARVE_LIMIT consecutive
//   LSU grants with IFU waiting, IFU wins once. A watchdog flags
//   transactions stuck in REQ+RSP (sticky timeout_err).
//   Ports: clk, rst (async, active-high)
//          ifu  - slave port from instruction fetch (read only)
//          lsu  - slave port from load/store unit
//          mem  - master port to memory
//          busy - not IDLE, timeout_err - sticky hang flag
//
//   state | meaning
//   IDLE  | no transaction; pick a winner, accept its request
//   REQ   | registered request on mem, waiting for mem req_ready
//   RSP   | routing mem response to the granted requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ImmWidth,
  parameter int DATA_W       = ImmWidth,
  parameter int STARVE_LIMIT = DefStarveLimit,
  parameter int TIMEOUT_CYC  = DefTimeoutCyc
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    ifu,
  mem_port_arbiter_if.slave    lsu,
  mem_port_arbiter_if.master   mem,
  output logic                 busy,
  output logic                 timeout_err
);

  // Legacy-compatible encodings mirroring the package enum.
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] RSP  = ST_RSP;

  localparam int               StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [1:0]          state;
  grant_e              grant;
  logic [StarveW-1:0]  starveCnt;

  logic [ADDR_W-1:0]   addrQ;
  logic                wenQ;
  logic [DATA_W-1:0]   wdataQ;
  logic [DATA_W/8-1:0] wmaskQ;

  logic inIdle;
  logic lsuWins;
  logic ifuWins;
  logic lsuFire;
  logic ifuFire;
  logic rspFire;

  // IFU is read-only; its write-side fields are intentionally ignored.
  logic unusedIfu;
  assign unusedIfu = ^{ifu.wen, ifu.wdata, ifu.wmask};

  // Ready is held low while rst is asserted even though state reads IDLE.
  assign inIdle  = (state == IDLE) && !rst;
  assign lsuWins = lsu.req_valid && !(ifu.req_valid && (starveCnt == StarveMax));
  assign ifuWins = ifu.req_valid && !lsuWins;

  assign lsu.req_ready = inIdle && lsuWins;
  assign ifu.req_ready = inIdle && ifuWins;
  assign lsuFire       = lsu.req_ready;
  assign ifuFire       = ifu.req_ready;

  assign mem.req_valid = (state == REQ);
  assign mem.addr      = addrQ;
  assign mem.wen       = wenQ;
  assign mem.wdata     = wdataQ;
  assign mem.wmask     = wmaskQ;

  always_comb begin
    mem.rsp_ready = 1'b0;
    if (state == RSP) begin
      if (grant == GNT_IFU) mem.rsp_ready = ifu.rsp_ready;
      else if (grant == GNT_LSU) mem.rsp_ready = lsu.rsp_ready;
    end
  end

  assign ifu.rsp_valid = (state == RSP) && (grant == GNT_IFU) && mem.rsp_valid;
  assign lsu.rsp_valid = (state == RSP) && (grant == GNT_LSU) && mem.rsp_valid;
  assign ifu.rsp_data  = mem.rsp_data;
  assign lsu.rsp_data  = mem.rsp_data;

  assign rspFire = (state == RSP) && mem.rsp_valid && mem.rsp_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      starveCnt <= '0;
      addrQ     <= '0;
      wenQ      <= 1'b0;
      wdataQ    <= '0;
      wmaskQ    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsuFire) begin
            addrQ  <= lsu.addr;
            wenQ   <= lsu.wen;
            wdataQ <= lsu.wdata;
            wmaskQ <= lsu.wmask;
            grant  <= GNT_LSU;
            state  <= REQ;
            if (!ifu.req_valid) begin
              starveCnt <= '0;
            end else if (starveCnt != StarveMax) begin
              starveCnt <= starveCnt + StarveW'(1);
            end
          end else if (ifuFire) begin
            addrQ     <= ifu.addr;
            wenQ      <= 1'b0;
            wdataQ    <= '0;
            wmaskQ    <= '0;
            grant     <= GNT_IFU;
            state     <= REQ;
            starveCnt <= '0;
          end
        end
        REQ: begin
          if (mem.req_ready) state <= RSP;
        end
        RSP: begin
          if (rspFire) begin
            state <= IDLE;
            grant <= GNT_NONE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) uWatchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (lsuFire || ifuFire),
    .en       (state != IDLE),
    .overflow (timeout_err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  logic timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifuBus ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) lsuBus ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) memBus ();

  mem_port_arbiter #(
    .ADDR_W       (64),
    .DATA_W       (64),
    .STARVE_LIMIT (4),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu         (ifuBus),
    .lsu         (lsuBus),
    .mem         (memBus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 in IDLE with requester inputs already set; returns
  // at posedge+1 back in IDLE after a zero-wait memory transaction.
  task automatic runTxn(input string tag, input grant_e expWho, input logic [63:0] expAddr,
                        input logic expWen, input logic [63:0] expWdata,
                        input logic [7:0] expMask, input logic [63:0] rdata);
    #1;
    checkVal({tag, "_rdy_ifu"}, 64'(ifuBus.req_ready), 64'(expWho == GNT_IFU));
    checkVal({tag, "_rdy_lsu"}, 64'(lsuBus.req_ready), 64'(expWho == GNT_LSU));
    tick();
    checkVal({tag, "_req_valid"}, 64'(memBus.req_valid), 64'd1);
    checkVal({tag, "_addr"}, memBus.addr, expAddr);
    checkVal({tag, "_wen"}, 64'(memBus.wen), 64'(expWen));
    checkVal({tag, "_wdata"}, memBus.wdata, expWdata);
    checkVal({tag, "_wmask"}, 64'(memBus.wmask), 64'(expMask));
    checkVal({tag, "_busy_req"}, 64'(busy), 64'd1);
    checkVal({tag, "_no_ack_req"}, 64'({ifuBus.req_ready, lsuBus.req_ready}), 64'd0);
    memBus.req_ready = 1'b1;
    tick();
    memBus.req_ready = 1'b0;
    memBus.rsp_valid = 1'b1;
    memBus.rsp_data  = rdata;
    ifuBus.rsp_ready = 1'b1;
    lsuBus.rsp_ready = 1'b1;
    #1;
    checkVal({tag, "_req_drop"}, 64'(memBus.req_valid), 64'd0);
    checkVal({tag, "_rspv_ifu"}, 64'(ifuBus.rsp_valid), 64'(expWho == GNT_IFU));
    checkVal({tag, "_rspv_lsu"}, 64'(lsuBus.rsp_valid), 64'(expWho == GNT_LSU));
    checkVal({tag, "_rsp_data"},
             (expWho == GNT_IFU) ? ifuBus.rsp_data : lsuBus.rsp_data, rdata);
    checkVal({tag, "_mem_rsp_rdy"}, 64'(memBus.rsp_ready), 64'd1);
    tick();
    memBus.rsp_valid = 1'b0;
    ifuBus.rsp_ready = 1'b0;
    lsuBus.rsp_ready = 1'b0;
    checkVal({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: got=running expected=finished");
    $fatal(1, "time limit");
  end

  grant_e starveSeq [7];
  grant_e who;
  logic [63:0] expA;

  initial begin
    rst = 1'b1;
    ifuBus.req_valid = 1'b0; ifuBus.addr = '0; ifuBus.wen = 1'b0;
    ifuBus.wdata = '0; ifuBus.wmask = '0; ifuBus.rsp_ready = 1'b0;
    lsuBus.req_valid = 1'b0; lsuBus.addr = '0; lsuBus.wen = 1'b0;
    lsuBus.wdata = '0; lsuBus.wmask = '0; lsuBus.rsp_ready = 1'b0;
    memBus.req_ready = 1'b0; memBus.rsp_valid = 1'b0; memBus.rsp_data = '0;

    // Reset state, with requests pending during reset.
    tick();
    ifuBus.req_valid = 1'b1;
    lsuBus.req_valid = 1'b1;
    #1;
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_req_valid", 64'(memBus.req_valid), 64'd0);
    checkVal("rst_rdy", 64'({ifuBus.req_ready, lsuBus.req_ready}), 64'd0);
    checkVal("rst_rspv", 64'({ifuBus.rsp_valid, lsuBus.rsp_valid}), 64'd0);
    checkVal("rst_mem_fields", memBus.addr | memBus.wdata | 64'(memBus.wmask) | 64'(memBus.wen), 64'd0);
    checkVal("rst_timeout", 64'(timeout_err), 64'd0);
    ifuBus.req_valid = 1'b0;
    lsuBus.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // IFU-only fetch.
    ifuBus.req_valid = 1'b1;
    ifuBus.addr      = 64'h8000_0000;
    runTxn("ifu_fetch", GNT_IFU, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0013);
    ifuBus.req_valid = 1'b0;

    // Simultaneous IFU + LSU store: LSU first, then IFU.
    ifuBus.req_valid = 1'b1;
    ifuBus.addr      = 64'h8000_0100;
    lsuBus.req_valid = 1'b1;
    lsuBus.addr      = 64'h8000_9008;
    lsuBus.wen       = 1'b1;
    lsuBus.wdata     = 64'hDEAD_BEEF;
    lsuBus.wmask     = 8'hFF;
    runTxn("both_lsu", GNT_LSU, 64'h8000_9008, 1'b1, 64'hDEAD_BEEF, 8'hFF, 64'h5555);
    lsuBus.req_valid = 1'b0;
    runTxn("both_ifu", GNT_IFU, 64'h8000_0100, 1'b0, 64'd0, 8'h00, 64'h0000_0093);
    ifuBus.req_valid = 1'b0;

    // Starvation: IFU held valid, LSU issues 6 loads.
    starveSeq = '{GNT_LSU, GNT_LSU, GNT_LSU, GNT_LSU, GNT_IFU, GNT_LSU, GNT_LSU};
    ifuBus.req_valid = 1'b1;
    ifuBus.addr      = 64'h8000_0200;
    lsuBus.req_valid = 1'b1;
    lsuBus.wen       = 1'b0;
    lsuBus.wdata     = '0;
    lsuBus.wmask     = '0;
    for (int i = 0; i < 7; i++) begin
      who = starveSeq[i];
      lsuBus.addr = 64'h8000_1000 + 64'(i * 8);
      expA = (who == GNT_LSU) ? 64'h8000_1000 + 64'(i * 8) : 64'h8000_0200;
      runTxn($sformatf("starve%0d", i), who, expA, 1'b0, 64'd0, 8'h00, 64'h1000 + 64'(i));
      if (i == 3) checkVal("starve_cnt_sat", 64'(dut.starveCnt), 64'd4);
      if (i == 4) checkVal("starve_cnt_clr", 64'(dut.starveCnt), 64'd0);
    end
    ifuBus.req_valid = 1'b0;
    lsuBus.req_valid = 1'b0;

    // Memory stalls request for 3 cycles while upstream churns.
    lsuBus.req_valid = 1'b1;
    lsuBus.addr      = 64'h8000_2000;
    lsuBus.wen       = 1'b1;
    lsuBus.wdata     = 64'h1122_3344_5566_7788;
    lsuBus.wmask     = 8'h0F;
    #1;
    checkVal("stall_accept", 64'(lsuBus.req_ready), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      lsuBus.addr      = 64'h9000_0000 + 64'(k);
      lsuBus.wdata     = 64'hFFFF_0000 + 64'(k);
      lsuBus.wmask     = 8'hF0;
      ifuBus.req_valid = 1'b1;
      #1;
      checkVal($sformatf("stall_addr%0d", k), memBus.addr, 64'h8000_2000);
      checkVal($sformatf("stall_wdata%0d", k), memBus.wdata, 64'h1122_3344_5566_7788);
      checkVal($sformatf("stall_wmask%0d", k), 64'(memBus.wmask), 64'h0F);
      checkVal($sformatf("stall_valid%0d", k), 64'(memBus.req_valid), 64'd1);
      checkVal($sformatf("stall_noack%0d", k), 64'({ifuBus.req_ready, lsuBus.req_ready}), 64'd0);
      tick();
    end
    lsuBus.req_valid = 1'b0;
    ifuBus.req_valid = 1'b0;
    memBus.req_ready = 1'b1;
    tick();
    memBus.req_ready = 1'b0;
    memBus.rsp_valid = 1'b1;
    lsuBus.rsp_ready = 1'b1;
    #1;
    checkVal("stall_rspv", 64'(lsuBus.rsp_valid), 64'd1);
    tick();
    memBus.rsp_valid = 1'b0;
    lsuBus.rsp_ready = 1'b0;
    checkVal("stall_done", 64'(busy), 64'd0);
    checkVal("no_timeout_yet", 64'(timeout_err), 64'd0);

    // Hung response: timeout after 16 cycles in REQ+RSP.
    ifuBus.req_valid = 1'b1;
    ifuBus.addr      = 64'h8000_3000;
    tick();
    ifuBus.req_valid = 1'b0;
    memBus.req_ready = 1'b1;
    tick();
    memBus.req_ready = 1'b0;
    repeat (14) tick();
    checkVal("timeout_15", 64'(timeout_err), 64'd0);
    tick();
    checkVal("timeout_16", 64'(timeout_err), 64'd1);
    repeat (5) tick();
    checkVal("timeout_sticky", 64'(timeout_err), 64'd1);
    checkVal("timeout_still_busy", 64'(busy), 64'd1);

    // Asynchronous reset in RSP.
    memBus.rsp_valid = 1'b1;
    memBus.rsp_data  = 64'hABCD;
    #1;
    checkVal("pre_rst_rspv", 64'(ifuBus.rsp_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    checkVal("arst_busy", 64'(busy), 64'd0);
    checkVal("arst_req_valid", 64'(memBus.req_valid), 64'd0);
    checkVal("arst_rspv", 64'({ifuBus.rsp_valid, lsuBus.rsp_valid}), 64'd0);
    checkVal("arst_timeout", 64'(timeout_err), 64'd0);
    memBus.rsp_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    ifuBus.req_valid = 1'b1;
    ifuBus.addr      = 64'h8000_4000;
    runTxn("post_rst", GNT_IFU, 64'h8000_4000, 1'b0, 64'd0, 8'h00, 64'h0000_0073);
    ifuBus.req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
